// File: rtl/scan_mux_if.sv
// Bus bundle for scan_mux: channel data in, select/mode/hold
// controls, registered data, channel index and change pulse out.
interface scan_mux_if #(
  parameter int W    = 1,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic [N*W-1:0]  data_in;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            hold;
  logic [W-1:0]    data_out;
  logic [SELW-1:0] ch_out;
  logic            ch_change;

  modport master (
    output data_in, sel, mode, hold,
    input  data_out, ch_out, ch_change
  );

  modport slave (
    input  data_in, sel, mode, hold,
    output data_out, ch_out, ch_change
  );
endinterface

// File: rtl/scan_mux.sv
// Registered N-channel W-bit mux: manual select or round-robin
// scan with programmable dwell, plus a channel-change pulse.
module scan_mux #(
  parameter int W     = 1,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input logic       clk,
  input logic       rst,
  scan_mux_if.slave bus
);
  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  localparam logic [SELW:0]   NUM  = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N-1);
  localparam logic [15:0]     CMAX = 16'(DWELL-1);

  state_e          state_q, state_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     cnt_cur;
  logic [W-1:0]    dout_q, dout_d;
  logic            chg_q, chg_d;
  logic            sel_ok;

  assign sel_ok = {1'b0, bus.sel} < NUM;

  // A scan entered from manual always counts from zero
  assign cnt_cur = (state_q == SCAN) ? cnt_q : '0;

  always_comb begin
    state_d = bus.mode ? SCAN : MANUAL;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    unique case (state_d)
      MANUAL: begin
        cnt_d = '0;
        if (sel_ok) ch_d = bus.sel;
      end
      SCAN: begin
        if (!bus.hold) begin
          if (cnt_cur == CMAX) begin
            cnt_d = '0;
            ch_d  = (ch_q == LAST) ? '0
                                   : ch_q + SELW'(1);
          end else begin
            cnt_d = cnt_cur + 16'd1;
          end
        end
      end
      default: ;
    endcase
    dout_d = bus.data_in[ch_d*W +: W];
    chg_d  = (ch_d != ch_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MANUAL;
      ch_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      chg_q   <= chg_d;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.ch_out    = ch_q;
  assign bus.ch_change = chg_q;
endmodule

// File: tb/tb_scan_mux.sv
// Vector-table bench for scan_mux: a 4-channel/dwell-3 instance
// and a 3-channel/dwell-2 instance for invalid-select cases.
module tb_scan_mux;
  typedef struct {
    logic        m;
    logic        h;
    logic [1:0]  s;
    logic [15:0] d;
    logic [1:0]  ec;
    logic [3:0]  ed;
    logic        ep;
  } vec_t;

  typedef struct {
    logic [1:0] ec;
    logic [3:0] ed;
    logic       ep;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  exp_t exp_q[$];
  vec_t t4[$];
  vec_t t3[$];

  localparam logic [15:0] D = 16'hDCBA;
  localparam logic [15:0] E = 16'h0987;

  scan_mux_if #(.W(4), .N(4), .SELW(2)) b4 ();
  scan_mux_if #(.W(4), .N(3), .SELW(2)) b3 ();

  scan_mux #(
    .W(4), .N(4), .SELW(2), .DWELL(3)
  ) u4 (
    .clk(clk),
    .rst(rst),
    .bus(b4.slave)
  );

  scan_mux #(
    .W(4), .N(3), .SELW(2), .DWELL(2)
  ) u3 (
    .clk(clk),
    .rst(rst),
    .bus(b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t V(
    input logic m, input logic h,
    input logic [1:0] s, input logic [15:0] d,
    input logic [1:0] ec, input logic [3:0] ed,
    input logic ep
  );
    vec_t v;
    v.m = m; v.h = h; v.s = s; v.d = d;
    v.ec = ec; v.ed = ed; v.ep = ep;
    return v;
  endfunction

  task automatic chk(
    input string nm, input int act, input int exp
  );
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic apply(
    input int u, input vec_t v, input string nm
  );
    exp_t e;
    if (u == 0) begin
      b4.mode = v.m; b4.hold = v.h;
      b4.sel = v.s; b4.data_in = v.d;
    end else begin
      b3.mode = v.m; b3.hold = v.h;
      b3.sel = v.s; b3.data_in = v.d[11:0];
    end
    exp_q.push_back('{v.ec, v.ed, v.ep});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      if (u == 0) begin
        chk({nm, "_ch"}, int'(b4.ch_out), int'(e.ec));
        chk({nm, "_dat"}, int'(b4.data_out), int'(e.ed));
        chk({nm, "_chg"}, int'(b4.ch_change), int'(e.ep));
      end else begin
        chk({nm, "_ch"}, int'(b3.ch_out), int'(e.ec));
        chk({nm, "_dat"}, int'(b3.data_out), int'(e.ed));
        chk({nm, "_chg"}, int'(b3.ch_change), int'(e.ep));
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    b4.mode = 1'b0; b4.hold = 1'b0;
    b4.sel = '0; b4.data_in = D;
    b3.mode = 1'b0; b3.hold = 1'b0;
    b3.sel = '0; b3.data_in = E[11:0];

    // manual select, then data tracking, then same-sel no pulse
    t4.push_back(V(0, 0, 2, D,        2, 4'hC, 1));
    t4.push_back(V(0, 0, 2, D,        2, 4'hC, 0));
    t4.push_back(V(0, 0, 2, 16'hD5BA, 2, 4'h5, 0));
    t4.push_back(V(0, 0, 0, D,        0, 4'hA, 1));
    t4.push_back(V(0, 0, 0, D,        0, 4'hA, 0));
    // full rotation with wrap
    t4.push_back(V(1, 0, 0, D, 0, 4'hA, 0));
    t4.push_back(V(1, 0, 0, D, 0, 4'hA, 0));
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 1));
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 0));
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 0));
    t4.push_back(V(1, 0, 0, D, 2, 4'hC, 1));
    t4.push_back(V(1, 0, 0, D, 2, 4'hC, 0));
    t4.push_back(V(1, 0, 0, D, 2, 4'hC, 0));
    t4.push_back(V(1, 0, 0, D, 3, 4'hD, 1));
    t4.push_back(V(1, 0, 0, D, 3, 4'hD, 0));
    t4.push_back(V(1, 0, 0, D, 3, 4'hD, 0));
    t4.push_back(V(1, 0, 0, D, 0, 4'hA, 1));
    // reach cnt==2, hold 5 cycles, data still tracks
    t4.push_back(V(1, 0, 0, D,        0, 4'hA, 0));
    t4.push_back(V(1, 0, 0, D,        0, 4'hA, 0));
    t4.push_back(V(1, 1, 0, D,        0, 4'hA, 0));
    t4.push_back(V(1, 1, 0, D,        0, 4'hA, 0));
    t4.push_back(V(1, 1, 0, 16'hDCB7, 0, 4'h7, 0));
    t4.push_back(V(1, 1, 0, D,        0, 4'hA, 0));
    t4.push_back(V(1, 1, 0, D,        0, 4'hA, 0));
    t4.push_back(V(1, 0, 0, D,        1, 4'hB, 1));
    // manual wins over dwell expiry, then DWELL-cycle hold of ch3
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 0));
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 0));
    t4.push_back(V(0, 0, 3, D, 3, 4'hD, 1));
    t4.push_back(V(1, 0, 0, D, 3, 4'hD, 0));
    t4.push_back(V(1, 0, 0, D, 3, 4'hD, 0));
    t4.push_back(V(1, 0, 0, D, 0, 4'hA, 1));
    // scan up to channel 2 ahead of the async reset
    t4.push_back(V(1, 0, 0, D, 0, 4'hA, 0));
    t4.push_back(V(1, 0, 0, D, 0, 4'hA, 0));
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 1));
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 0));
    t4.push_back(V(1, 0, 0, D, 1, 4'hB, 0));
    t4.push_back(V(1, 0, 0, D, 2, 4'hC, 1));
    t4.push_back(V(1, 0, 0, D, 2, 4'hC, 0));

    // N=3: invalid sel ignored, then scan wrap 2->0
    t3.push_back(V(0, 0, 1, E, 1, 4'h8, 1));
    t3.push_back(V(0, 0, 3, E, 1, 4'h8, 0));
    t3.push_back(V(0, 0, 3, E, 1, 4'h8, 0));
    t3.push_back(V(0, 0, 0, E, 0, 4'h7, 1));
    t3.push_back(V(1, 0, 0, E, 0, 4'h7, 0));
    t3.push_back(V(1, 0, 0, E, 1, 4'h8, 1));
    t3.push_back(V(1, 0, 0, E, 1, 4'h8, 0));
    t3.push_back(V(1, 0, 0, E, 2, 4'h9, 1));
    t3.push_back(V(1, 0, 0, E, 2, 4'h9, 0));
    t3.push_back(V(1, 0, 0, E, 0, 4'h7, 1));
    t3.push_back(V(0, 0, 3, E, 0, 4'h7, 0));

    #12;
    rst = 1'b0;
    #1;
    chk("rst_dat", int'(b4.data_out), 0);
    chk("rst_ch", int'(b4.ch_out), 0);
    chk("rst_chg", int'(b4.ch_change), 0);

    foreach (t4[i])
      apply(0, t4[i], $sformatf("n4_v%0d", i));

    // async reset mid-cycle while scanning on channel 2
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dat", int'(b4.data_out), 0);
    chk("arst_ch", int'(b4.ch_out), 0);
    chk("arst_chg", int'(b4.ch_change), 0);
    #2;
    rst = 1'b0;
    apply(0, V(1, 0, 0, D, 0, 4'hA, 0), "post_rst0");
    apply(0, V(1, 0, 0, D, 0, 4'hA, 0), "post_rst1");
    apply(0, V(1, 0, 0, D, 1, 4'hB, 1), "post_rst2");

    foreach (t3[i])
      apply(1, t3[i], $sformatf("n3_v%0d", i));

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end
endmodule
